// File: rtl/score_accumulator.sv
// Per-game score generator: latches player, scores ticks with a level
// multiplier, and holds the final score in REPORT for the tracker.
module score_accumulator #(
  parameter int REPORT_HOLD = 16,
  parameter int LEVEL_TICKS = 32,
  parameter int MAX_LEVEL   = 4,
  parameter int MAX_SCORE   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tick,
  input  logic        crash,
  input  logic        pause,
  input  logic [4:0]  player_in,
  output logic [13:0] Score,
  output logic [3:0]  score_req,
  output logic [4:0]  playerID,
  output logic [2:0]  level,
  output logic        busy
);

  localparam int TW = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
  localparam int HW = $clog2(REPORT_HOLD);

  localparam logic [14:0]   MAX15 = 15'(MAX_SCORE);
  localparam logic [TW-1:0] TLAST = TW'(LEVEL_TICKS - 1);
  localparam logic [HW-1:0] HLAST = HW'(REPORT_HOLD - 1);
  localparam logic [2:0]    LMAX  = 3'(MAX_LEVEL);

  // Encodings double as the score_req code seen downstream.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RUN    = 4'd1,
    PAUSE  = 4'd2,
    REPORT = 4'd5
  } state_t;

  state_t        state, state_nx;
  logic [13:0]   score_nx;
  logic [4:0]    pid_nx;
  logic [2:0]    level_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [14:0]   sum;

  assign sum = {1'b0, Score} + {12'd0, level};

  always_comb begin
    state_nx = state;
    score_nx = Score;
    pid_nx   = playerID;
    level_nx = level;
    tcnt_nx  = tcnt;
    hcnt_nx  = hcnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          score_nx = '0;
          pid_nx   = player_in;
          level_nx = 3'd1;
          tcnt_nx  = '0;
        end
      end
      RUN: begin
        if (tick) begin
          score_nx = (sum > MAX15) ? MAX15[13:0] : sum[13:0];
          if (tcnt == TLAST) begin
            tcnt_nx = '0;
            if (level < LMAX)
              level_nx = level + 3'd1;
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end
        if (crash) begin
          state_nx = REPORT;
          hcnt_nx  = '0;
        end else if (pause) begin
          state_nx = PAUSE;
        end
      end
      PAUSE: begin
        if (crash) begin
          state_nx = REPORT;
          hcnt_nx  = '0;
        end else if (!pause) begin
          state_nx = RUN;
        end
      end
      REPORT: begin
        hcnt_nx = hcnt + 1'b1;
        if (hcnt == HLAST) begin
          state_nx = IDLE;
          hcnt_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        score_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      Score    <= '0;
      playerID <= '0;
      level    <= 3'd1;
      tcnt     <= '0;
      hcnt     <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      Score    <= score_nx;
      playerID <= pid_nx;
      level    <= level_nx;
      tcnt     <= tcnt_nx;
      hcnt     <= hcnt_nx;
      busy     <= (state_nx == RUN) || (state_nx == PAUSE);
    end
  end

  assign score_req = state;

endmodule

// File: tb/tb_score_accumulator.sv
// Bench for score_accumulator: directed scenarios plus random traffic
// against a tick-count based reference model.
module tb_score_accumulator;

  localparam int RH = 16;
  localparam int LT = 32;
  localparam int ML = 4;
  localparam int MS = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic        crash = 1'b0;
  logic        pause = 1'b0;
  logic [4:0]  player_in = '0;
  logic [13:0] Score;
  logic [3:0]  score_req;
  logic [4:0]  playerID;
  logic [2:0]  level;
  logic        busy;

  int checks = 0;
  int failures = 0;

  int m_state, m_score, m_pid, m_n, m_rep;

  always #5 clk = ~clk;

  score_accumulator #(
    .REPORT_HOLD(RH),
    .LEVEL_TICKS(LT),
    .MAX_LEVEL(ML),
    .MAX_SCORE(MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tick(tick),
    .crash(crash),
    .pause(pause),
    .player_in(player_in),
    .Score(Score),
    .score_req(score_req),
    .playerID(playerID),
    .level(level),
    .busy(busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Level follows from how many ticks the game has scored so far.
  function automatic int m_level();
    int l = 1 + m_n / LT;
    return (l > ML) ? ML : l;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_score = 0;
    m_pid   = 0;
    m_n     = 0;
    m_rep   = 0;
  endtask

  task automatic model_clk();
    int lv = m_level();
    case (m_state)
      0: if (start) begin
        m_state = 1;
        m_score = 0;
        m_pid   = int'(player_in);
        m_n     = 0;
      end
      1: begin
        if (tick) begin
          m_score = (m_score + lv > MS) ? MS : m_score + lv;
          m_n++;
        end
        if (crash) begin
          m_state = 5;
          m_rep   = 0;
        end else if (pause) begin
          m_state = 2;
        end
      end
      2: if (crash) begin
        m_state = 5;
        m_rep   = 0;
      end else if (!pause) begin
        m_state = 1;
      end
      5: begin
        m_rep++;
        if (m_rep == RH) m_state = 0;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check("score", int'(Score), m_score);
    check("req", int'(score_req), m_state);
    check("pid", int'(playerID), m_pid);
    check("level", int'(level), m_level());
    check("busy", int'(busy), int'(m_state == 1 || m_state == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit st, input bit tk, input bit cr,
                       input bit pa, input logic [4:0] pid);
    start     = st;
    tick      = tk;
    crash     = cr;
    pause     = pa;
    player_in = pid;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 5'(i));
  endtask

  initial begin
    int cnt;
    int k;
    bit p;

    model_reset();
    #12;
    compare_all();
    rst = 1'b1;

    // Short game: player 7, three ticks, crash, full report window.
    drive(1, 0, 0, 0, 5'd7);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 5'(i + 20));
    drive(0, 0, 1, 0, 5'd0);
    check("t1_score", int'(Score), 3);
    check("t1_pid", int'(playerID), 7);
    cnt = (score_req == 4'd5) ? 1 : 0;
    for (int i = 0; i < RH + 4; i++) begin
      drive(0, 0, 0, 0, 5'd0);
      if (score_req == 4'd5) cnt++;
    end
    check("t1_hold", cnt, RH);
    check("t1_req_after", int'(score_req), 0);

    // Level step after 32 ticks.
    drive(1, 0, 0, 0, 5'd12);
    for (int i = 0; i < 32; i++) drive(0, 1, 0, 0, 5'd0);
    check("t2_level", int'(level), 2);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 5'd0);
    check("t2_score", int'(Score), 48);
    drive(0, 0, 1, 0, 5'd0);
    idle(RH + 2);

    // Saturation at MAX_SCORE.
    drive(1, 0, 0, 0, 5'd3);
    for (int i = 0; i < 96; i++) drive(0, 1, 0, 0, 5'd0);
    check("t3_level", int'(level), ML);
    k = 0;
    while (Score < 14'(MS) && k < 3000) begin
      drive(0, 1, 0, 0, 5'd0);
      k++;
    end
    check("t3_sat", int'(Score), MS);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 5'd0);
    check("t3_hold", int'(Score), MS);
    drive(0, 0, 1, 0, 5'd0);
    idle(RH + 2);

    // Pause suppresses ticks.
    drive(1, 0, 0, 0, 5'd9);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 5'd0);
    for (int i = 0; i < 10; i++) drive(0, bit'(i % 2), 0, 1, 5'd0);
    check("t4_req", int'(score_req), 2);
    check("t4_score", int'(Score), 3);
    drive(0, 0, 0, 0, 5'd0);
    check("t4_resume", int'(score_req), 1);
    drive(0, 1, 0, 0, 5'd0);
    check("t4_tick", int'(Score), 4);
    drive(0, 0, 1, 1, 5'd0);
    check("t4_crash_wins", int'(score_req), 5);
    idle(RH + 2);

    // Tick + crash together, then start during REPORT.
    drive(1, 0, 0, 0, 5'd21);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 5'd0);
    drive(0, 1, 1, 0, 5'd0);
    check("t5_score", int'(Score), 11);
    check("t5_req", int'(score_req), 5);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, 5'd2);
    check("t5_no_restart", int'(playerID), 21);
    idle(RH);
    check("t5_idle", int'(score_req), 0);

    // Asynchronous reset mid-game.
    drive(1, 0, 0, 0, 5'd30);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 5'd0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("t6_req", int'(score_req), 0);
    #1;
    rst = 1'b1;
    idle(4);

    // Random traffic.
    p = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) p = ~p;
      drive($urandom_range(0, 7) == 0, bit'($urandom_range(0, 1)),
            $urandom_range(0, 99) == 0, p, 5'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_accumulator.md
# score_accumulator

Per-game score generator upstream of the score tracker. It latches the player ID at game start, accumulates points from gameplay tick pulses with a level-based multiplier, and ends the game on a crash pulse. It then presents the final score with `score_req` = 5 for a fixed hold window, which is the handshake the tracker waits on.

## Interface
Parameters:
- `REPORT_HOLD`, 16: cycles `score_req` stays at 5 after game end; must be ≥ 10.
- `LEVEL_TICKS`, 32: scored ticks per level step.
- `MAX_LEVEL`, 4: highest multiplier.
- `MAX_SCORE`, 9999: saturation value; must fit 14 bits.

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a game from IDLE.
- `tick` input 1: one-cycle point pulse from game logic.
- `crash` input 1: one-cycle pulse; ends the current game.
- `pause` input 1: level; high suspends scoring.
- `player_in` input 5: player ID, sampled on `start`.
- `Score` output 14: current or final score, binary.
- `score_req` output 4: state code: 0 IDLE, 1 RUN, 2 PAUSE, 5 REPORT.
- `playerID` output 5: ID latched at start.
- `level` output 3: current multiplier, 1..`MAX_LEVEL`.
- `busy` output 1: high in RUN and PAUSE.

## Operation
- Reset (asynchronous, `rst` = 0): state IDLE, `Score` = 0, `score_req` = 0, `playerID` = 0, `level` = 1, `busy` = 0, tick and hold counters = 0.
- **IDLE**
  - `start` = 1 → RUN. Same edge: `Score` ← 0, `playerID` ← `player_in`, `level` ← 1, tick counter ← 0.
  - `tick`, `crash` and `pause` are ignored.
  - `Score` keeps the last game's value for display.
- **RUN**
  - `tick` = 1: `Score` ← min(`Score` + `level`, `MAX_SCORE`). Compute the sum 15 bits wide; never wrap.
  - Each tick also increments the tick counter. When the counter reaches `LEVEL_TICKS` − 1 on a tick:
    - counter ← 0;
    - `level` ← `level` + 1 if `level` < `MAX_LEVEL`, otherwise unchanged.
  - The level bump takes effect from the next tick.
  - `crash` = 1 → REPORT; hold counter ← 0.
  - Otherwise `pause` = 1 → PAUSE.
- **PAUSE**
  - `tick` is ignored; `Score`, `level` and the tick counter are frozen.
  - `crash` = 1 → REPORT.
  - Otherwise `pause` = 0 → RUN.
- **REPORT**
  - `Score`, `playerID` and `level` are frozen.
  - Hold counter increments every cycle. When it reaches `REPORT_HOLD` − 1 → IDLE.
  - `start`, `tick` and `pause` are ignored.
- `start` outside IDLE is ignored. `player_in` changes outside the start edge have no effect.
- Simultaneous events in RUN:
  - `tick` + `crash`: the tick is scored, then the state moves to REPORT; the final score includes that tick.
  - `crash` + `pause`: crash wins.
  - `tick` + `pause`: the tick is scored, then the state moves to PAUSE.
- Unused state encodings → IDLE with `Score` = 0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `score_req` changes on the same edge as the state. It is 5 for exactly `REPORT_HOLD` cycles, starting the cycle after the crash edge.
- `Score` is final and stable for the whole REPORT window, so the downstream stage may sample it on any cycle there.
- After REPORT, `score_req` is 0 for at least one cycle before any new game can start. This guarantees the downstream stage sees `score_req` ≠ 5 between games.
- Start latency: `start` at edge N → `score_req` = 1 and `busy` = 1 after edge N.
- Tick latency: `tick` at edge N → updated `Score` visible after edge N.
- Reset mid-game: immediate return to reset values. No report is issued for the aborted game.

## Test plan
- Reset, then `start` with `player_in` = 7, then 3 ticks, then `crash` → `playerID` = 7, `Score` = 3, `score_req` = 5 for exactly 16 cycles, then 0.
- 40 ticks in RUN → `level` = 2 after the 32nd tick; final `Score` = 32 + 8×2 = 48.
- Run to `level` = 4, then preload near the cap (`Score` = 9997) and tick once → `Score` = 9999. Further ticks hold 9999.
- `pause` high for 10 cycles with 5 ticks during it → `score_req` = 2 and `Score` unchanged. On release, `score_req` = 1 and the next tick scores.
- `tick` and `crash` in the same cycle at `Score` = 10, `level` = 1 → REPORT with `Score` = 11.
- `start` during REPORT is ignored and no restart occurs. Assert `rst` mid-RUN → all outputs return to reset values asynchronously, with no `score_req` = 5 pulse.
